// File: rtl/instructions.sv
// rtl/instructions.sv - shared ICU instruction set and program word types
// Holds instruction_t (MC14500-style 4-bit opcodes), the program word layout used by
// the sequencer, the opcode field width and the opcode injected when the ICU must idle.
package instructions;

  typedef enum logic [3:0] {
    NOPO = 4'h0,
    LD   = 4'h1,
    LDC  = 4'h2,
    AND  = 4'h3,
    ANDC = 4'h4,
    OR   = 4'h5,
    ORC  = 4'h6,
    XNOR = 4'h7,
    STO  = 4'h8,
    STOC = 4'h9,
    IEN  = 4'hA,
    OEN  = 4'hB,
    JMP  = 4'hC,
    RTN  = 4'hD,
    SKZ  = 4'hE,
    NOPF = 4'hF
  } instruction_t;

  localparam int PROG_OP_W   = 4;
  localparam int PROG_ADDR_W = 8;

  localparam instruction_t NOP_INJECT = NOPO;

  // Program word at the default address width: {opcode, address field}.
  typedef struct packed {
    instruction_t           op;
    logic [PROG_ADDR_W-1:0] addr;
  } prog_word_t;

endpackage

// File: rtl/icu_return_stack.sv
// rtl/icu_return_stack.sv - call/return address stack for the ICU sequencer
// Ports: clk, rst (sync, active-low); push_i/pop_i/data_i requests;
//   top_o most recent return address, sp_o occupancy, full_o/empty_o status,
//   err_o sticky overflow/underflow/illegal push+pop flag.
module icu_return_stack #(
  parameter int  STACK_DEPTH = 4,
  parameter int  ADDR_W      = 8,
  localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic [SP_W-1:0]   sp_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              err_o
);

  logic [ADDR_W-1:0] entry_q [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              err_q, err_d;
  logic              do_pop, do_push;

  assign full_o  = (sp_q == SP_W'(STACK_DEPTH));
  assign empty_o = (sp_q == '0);

  // Pop wins over push; a simultaneous request is flagged but still pops.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && !pop_i && !full_o;

  always_comb begin
    top_o = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (SP_W'(i + 1) == sp_q) top_o = entry_q[i];
    end
  end

  always_comb begin
    sp_d  = sp_q;
    err_d = err_q;
    if (do_pop)       sp_d = sp_q - SP_W'(1);
    else if (do_push) sp_d = sp_q + SP_W'(1);
    if ((pop_i && empty_o) || (push_i && pop_i) || (push_i && !pop_i && full_o)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (SP_W'(i) == sp_q) entry_q[i] <= data_i;
      end
    end
  end

  assign sp_o  = sp_q;
  assign err_o = err_q;

endmodule

// File: rtl/icu_sequencer.sv
// rtl/icu_sequencer.sv - program sequencer feeding the 1-bit ICU
// Ports: clk, rst (sync, active-low); run advance enable;
//   prog_we/prog_addr/prog_data program memory write;
//   jmp/rtn/flag_o/flag_f/rr_in status from the ICU;
//   instruction/io_addr current word; pc, sp, stack_err, halted, flag_o_seen status.
// Optional: ICU_SEQ_HALT_EN lets NOPF halt the sequencer until run rises again.
module icu_sequencer
  import instructions::*;
#(
  parameter int  ADDR_W      = 8,
  parameter int  STACK_DEPTH = 4,
  localparam int SP_W        = $clog2(STACK_DEPTH + 1),
  localparam int WORD_W      = PROG_OP_W + ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [WORD_W-1:0] prog_data,
  input  logic              jmp,
  input  logic              rtn,
  input  logic              flag_o,
  input  logic              flag_f,
  input  logic              rr_in,
  output instruction_t      instruction,
  output logic [ADDR_W-1:0] io_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [SP_W-1:0]   sp,
  output logic              stack_err,
  output logic              halted,
  output logic              flag_o_seen
);

  logic [WORD_W-1:0] mem [1 << ADDR_W];
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, word_addr, ret_addr;
  instruction_t      word_op;
  logic              active, skip_q, skip_d, jmp_e, rtn_e;
  logic              stk_empty, halted_q, flag_o_seen_q;
  logic              unused_full;

  assign word_op     = instruction_t'(mem[pc_q][WORD_W-1 -: PROG_OP_W]);
  assign word_addr   = mem[pc_q][ADDR_W-1:0];
  assign pc_inc      = pc_q + ADDR_W'(1);
  assign active      = run && !halted_q && rst;
  assign instruction = active ? word_op : NOP_INJECT;
  // Address stays live while run is low so an in-flight JMP still finds its target.
  assign io_addr     = rst ? word_addr : '0;

  // The ICU discards the word after a taken SKZ or an RTN; strobes raised
  // during that slot must not steer the PC.
  assign jmp_e  = jmp && !skip_q;
  assign rtn_e  = rtn && !skip_q;
  assign skip_d = !skip_q && (((instruction == SKZ) && !rr_in) || rtn);

  icu_return_stack #(
    .STACK_DEPTH(STACK_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_stack (
    .clk    (clk),
    .rst    (rst),
    .push_i (jmp_e),
    .pop_i  (rtn_e),
    .data_i (pc_inc),
    .top_o  (ret_addr),
    .sp_o   (sp),
    .full_o (unused_full),
    .empty_o(stk_empty),
    .err_o  (stack_err)
  );

  // Jumps and returns complete regardless of run; an overflowing jump is still taken.
  always_comb begin
    pc_d = pc_q;
    if (rtn_e)                  pc_d = stk_empty ? pc_inc : ret_addr;
    else if (jmp_e)             pc_d = word_addr;
    else if (run && !halted_q)  pc_d = pc_inc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q          <= '0;
      skip_q        <= 1'b0;
      flag_o_seen_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      skip_q        <= skip_d;
      flag_o_seen_q <= flag_o;
    end
  end

  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

`ifdef ICU_SEQ_HALT_EN
  logic run_q, halted_d;

  // A rising edge on run resumes; NOPF halts only when not in a skip slot.
  always_comb begin
    halted_d = halted_q;
    if (run && !run_q)                         halted_d = 1'b0;
    else if (flag_f && !skip_q && !halted_q)   halted_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      run_q    <= run;
      halted_q <= halted_d;
    end
  end
`else
  logic unused_flag_f;
  assign unused_flag_f = flag_f;
  assign halted_q      = 1'b0;
`endif

  assign pc          = pc_q;
  assign halted      = halted_q;
  assign flag_o_seen = flag_o_seen_q;

endmodule

// File: tb/tb_icu_sequencer.sv
// tb/tb_icu_sequencer.sv - self-checking bench for icu_sequencer
module tb_icu_sequencer;

  localparam logic [3:0] O_NOPO = 4'h0, O_LD = 4'h1, O_LDC = 4'h2, O_OR = 4'h5, O_STO = 4'h8;
  localparam logic [3:0] O_JMP = 4'hC, O_RTN = 4'hD, O_SKZ = 4'hE, O_NOPF = 4'hF;

  logic        clk = 1'b0, rst = 1'b0, run = 1'b0, prog_we = 1'b0;
  logic        jmp = 1'b0, rtn = 1'b0, flag_o = 1'b0, flag_f = 1'b0, rr_in = 1'b0;
  logic [7:0]  prog_addr = '0;
  logic [11:0] prog_data = '0;
  logic [3:0]  instruction;
  logic [7:0]  io_addr, pc;
  logic [2:0]  sp;
  logic        stack_err, halted, flag_o_seen;

  int n_pass = 0, n_total = 0;

  // Reference model: memory image, PC, return-address queue and status flags.
  int m_mem [256];
  int m_pc = 0;
  int m_stack [$];
  bit m_err = 0, m_halt = 0, m_skip = 0, m_run_prev = 0, m_fos = 0;
  bit rr_random = 1;

  always #5 clk = ~clk;

  icu_sequencer #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .jmp(jmp), .rtn(rtn), .flag_o(flag_o), .flag_f(flag_f),
    .rr_in(rr_in), .instruction(instruction), .io_addr(io_addr), .pc(pc), .sp(sp),
    .stack_err(stack_err), .halted(halted), .flag_o_seen(flag_o_seen)
  );

  function automatic logic [3:0] exp_op();
    if (!rst || !run || m_halt) return O_NOPO;
    return 4'(m_mem[m_pc] >> 8);
  endfunction

  function automatic logic [7:0] exp_io();
    if (!rst) return 8'h00;
    return 8'(m_mem[m_pc]);
  endfunction

  // ICU behaviour: raise the strobe matching the presented opcode; then advance one clock.
  task automatic cycle();
    logic [3:0] op;
    bit j, r, sk;
    op = exp_op();
    jmp = (op == O_JMP); rtn = (op == O_RTN); flag_f = (op == O_NOPF); flag_o = (op == O_NOPO);
    if (rr_random) rr_in = 1'($urandom_range(0, 1));
    j  = jmp && !m_skip;
    r  = rtn && !m_skip;
    sk = !m_skip && ((op == O_SKZ && !rr_in) || rtn);
    if (!rst) begin
      m_pc = 0; m_stack.delete(); m_err = 0; m_halt = 0; m_skip = 0; m_fos = 0; m_run_prev = 0;
    end else begin
      if (r) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin m_err = 1; m_pc = (m_pc + 1) % 256; end
        if (j) m_err = 1;
      end else if (j) begin
        if (m_stack.size() < 4) m_stack.push_back((m_pc + 1) % 256);
        else m_err = 1;
        m_pc = m_mem[m_pc] % 256;
      end else if (run && !m_halt) begin
        m_pc = (m_pc + 1) % 256;
      end
`ifdef ICU_SEQ_HALT_EN
      if (run && !m_run_prev) m_halt = 0;
      else if (flag_f && !m_skip && !m_halt) m_halt = 1;
`endif
      m_run_prev = run; m_skip = sk; m_fos = flag_o;
    end
    if (prog_we) m_mem[prog_addr] = int'(prog_data);
    @(posedge clk); #1;
  endtask

  task automatic load(input int a, input logic [3:0] op, input int ad);
    prog_we = 1'b1; prog_addr = 8'(a); prog_data = {op, 8'(ad)};
    cycle();
    prog_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; run = 1'b1;
    for (int a = 0; a < 256; a++) load(a, O_NOPO, 0);
    repeat (3) cycle();
    n_total++; if (pc !== 8'h00) $display("FAIL reset_pc: got %h expected 00", pc); else n_pass++;
    n_total++; if (sp !== 3'd0) $display("FAIL reset_sp: got %0d expected 0", sp); else n_pass++;
    n_total++; if (instruction !== O_NOPO) $display("FAIL reset_instr: got %h expected %h", instruction, O_NOPO); else n_pass++;
    n_total++; if (stack_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", stack_err); else n_pass++;
    n_total++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b expected 0", halted); else n_pass++;
    n_total++; if (io_addr !== 8'h00) $display("FAIL reset_io: got %h expected 00", io_addr); else n_pass++;
    n_total++; if (flag_o_seen !== 1'b0) $display("FAIL reset_fos: got %b expected 0", flag_o_seen); else n_pass++;
  endtask

  task automatic test_sequential();
    logic [3:0] ops [4] = '{O_LD, O_OR, O_STO, O_NOPO};
    rst = 1'b0; run = 1'b1;
    load(0, O_LD, 1); load(1, O_OR, 2); load(2, O_STO, 3);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++; if (pc !== 8'(i)) $display("FAIL seq_pc%0d: got %h expected %h", i, pc, 8'(i)); else n_pass++;
      n_total++; if (instruction !== ops[i]) $display("FAIL seq_op%0d: got %h expected %h", i, instruction, ops[i]); else n_pass++;
      n_total++; if (io_addr !== exp_io()) $display("FAIL seq_io%0d: got %h expected %h", i, io_addr, exp_io()); else n_pass++;
      n_total++; if (flag_o_seen !== m_fos) $display("FAIL seq_fos%0d: got %b expected %b", i, flag_o_seen, m_fos); else n_pass++;
      cycle();
    end
  endtask

  task automatic test_call_return();
    rst = 1'b0; run = 1'b1;
    load(5, O_JMP, 'h10); load('h12, O_RTN, 0); load(6, O_NOPO, 0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_total++; if (pc !== 8'(m_pc)) $display("FAIL call_walk%0d: got %h expected %h", i, pc, 8'(m_pc)); else n_pass++;
    end
    n_total++; if (pc !== 8'h10) $display("FAIL call_target: got %h expected 10", pc); else n_pass++;
    n_total++; if (sp !== 3'd1) $display("FAIL call_sp: got %0d expected 1", sp); else n_pass++;
    repeat (2) cycle();
    n_total++; if (instruction !== O_RTN) $display("FAIL call_rtn_op: got %h expected %h", instruction, O_RTN); else n_pass++;
    cycle();
    n_total++; if (pc !== 8'h06) $display("FAIL ret_pc: got %h expected 06", pc); else n_pass++;
    n_total++; if (sp !== 3'd0) $display("FAIL ret_sp: got %0d expected 0", sp); else n_pass++;
    cycle();
    n_total++; if (pc !== 8'h07) $display("FAIL ret_slot: got %h expected 07", pc); else n_pass++;
  endtask

  task automatic test_skip();
    rst = 1'b0; run = 1'b1; rr_random = 0; rr_in = 1'b0;
    load(0, O_SKZ, 0); load(1, O_JMP, 'h20);
    rst = 1'b1;
    cycle(); cycle();
    n_total++; if (pc !== 8'h02) $display("FAIL skz0_pc: got %h expected 02", pc); else n_pass++;
    n_total++; if (sp !== 3'd0) $display("FAIL skz0_sp: got %0d expected 0", sp); else n_pass++;
    rst = 1'b0; cycle();
    rr_in = 1'b1; rst = 1'b1;
    cycle(); cycle();
    n_total++; if (pc !== 8'h20) $display("FAIL skz1_pc: got %h expected 20", pc); else n_pass++;
    n_total++; if (sp !== 3'd1) $display("FAIL skz1_sp: got %0d expected 1", sp); else n_pass++;
    rr_random = 1;
  endtask

  task automatic test_halt();
    rst = 1'b0; run = 1'b1;
    load(0, O_LD, 0); load(1, O_LD, 0); load(5, O_NOPO, 0); load(7, O_NOPF, 0); load(8, O_LD, 'h44);
    rst = 1'b1;
    repeat (8) cycle();
    n_total++; if (pc !== 8'h08) $display("FAIL halt_pc: got %h expected 08", pc); else n_pass++;
`ifdef ICU_SEQ_HALT_EN
    n_total++; if (halted !== 1'b1) $display("FAIL halt_set: got %b expected 1", halted); else n_pass++;
    repeat (3) cycle();
    n_total++; if (pc !== 8'h08) $display("FAIL halt_hold: got %h expected 08", pc); else n_pass++;
    n_total++; if (instruction !== O_NOPO) $display("FAIL halt_nop: got %h expected %h", instruction, O_NOPO); else n_pass++;
    run = 1'b0; cycle(); run = 1'b1; cycle();
    n_total++; if (halted !== 1'b0) $display("FAIL halt_clear: got %b expected 0", halted); else n_pass++;
    n_total++; if (pc !== 8'h08) $display("FAIL halt_resume_pc: got %h expected 08", pc); else n_pass++;
    n_total++; if (instruction !== O_LD) $display("FAIL halt_resume_op: got %h expected %h", instruction, O_LD); else n_pass++;
    cycle();
    n_total++; if (pc !== 8'h09) $display("FAIL halt_next: got %h expected 09", pc); else n_pass++;
`else
    n_total++; if (halted !== 1'b0) $display("FAIL nohalt_flag: got %b expected 0", halted); else n_pass++;
    cycle();
    n_total++; if (pc !== 8'h09) $display("FAIL nohalt_pass: got %h expected 09", pc); else n_pass++;
    run = 1'b0; cycle(); run = 1'b1; cycle();
    n_total++; if (pc !== 8'h0A) $display("FAIL nohalt_run: got %h expected 0a", pc); else n_pass++;
`endif
    n_total++; if (pc !== 8'(m_pc)) $display("FAIL halt_model_pc: got %h expected %h", pc, 8'(m_pc)); else n_pass++;
    n_total++; if (io_addr !== exp_io()) $display("FAIL halt_model_io: got %h expected %h", io_addr, exp_io()); else n_pass++;
  endtask

  task automatic test_wrap();
    rst = 1'b0; run = 1'b1;
    load(0, O_JMP, 'hFE); load('hFE, O_NOPO, 0); load('hFF, O_NOPO, 0);
    rst = 1'b1;
    cycle(); cycle();
    n_total++; if (pc !== 8'hFF) $display("FAIL wrap_ff: got %h expected ff", pc); else n_pass++;
    prog_we = 1'b1; prog_addr = 8'hFF; prog_data = {O_LD, 8'h5A}; #1;
    n_total++; if (instruction !== O_NOPO) $display("FAIL wr_old_word: got %h expected %h", instruction, O_NOPO); else n_pass++;
    cycle(); prog_we = 1'b0;
    n_total++; if (pc !== 8'h00) $display("FAIL wrap_zero: got %h expected 00", pc); else n_pass++;
    cycle(); cycle();
    n_total++; if (instruction !== O_LD || io_addr !== 8'h5A) $display("FAIL wr_new_word: got %h/%h expected %h/5a", instruction, io_addr, O_LD); else n_pass++;
    run = 1'b0; prog_we = 1'b1; prog_addr = 8'hFF; prog_data = {O_LDC, 8'h33};
    cycle(); prog_we = 1'b0; run = 1'b1; #1;
    n_total++; if (instruction !== O_LDC || io_addr !== 8'h33) $display("FAIL wr_next_cycle: got %h/%h expected %h/33", instruction, io_addr, O_LDC); else n_pass++;
    n_total++; if (sp !== 3'(m_stack.size())) $display("FAIL wrap_sp: got %0d expected %0d", sp, m_stack.size()); else n_pass++;
  endtask

  task automatic test_overflow();
    rst = 1'b0; run = 1'b1;
    load(0, O_JMP, 'h40); load('h40, O_JMP, 'h50); load('h50, O_JMP, 'h60);
    load('h60, O_JMP, 'h70); load('h70, O_JMP, 'h80); load('h80, O_RTN, 0);
    load('h62, O_RTN, 0); load('h52, O_RTN, 0); load('h42, O_RTN, 0); load(2, O_RTN, 0);
    rst = 1'b1;
    repeat (4) cycle();
    n_total++; if (sp !== 3'd4 || stack_err !== 1'b0) $display("FAIL ovf_fill: got sp %0d err %b expected 4 0", sp, stack_err); else n_pass++;
    cycle();
    n_total++; if (pc !== 8'h80) $display("FAIL ovf_jump: got %h expected 80", pc); else n_pass++;
    n_total++; if (sp !== 3'd4) $display("FAIL ovf_sp: got %0d expected 4", sp); else n_pass++;
    n_total++; if (stack_err !== 1'b1) $display("FAIL ovf_err: got %b expected 1", stack_err); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      cycle();
      n_total++; if (pc !== 8'(m_pc) || sp !== 3'(m_stack.size())) $display("FAIL unwind%0d: got %h/%0d expected %h/%0d", i, pc, sp, 8'(m_pc), m_stack.size()); else n_pass++;
    end
    n_total++; if (pc !== 8'h03) $display("FAIL udf_pc: got %h expected 03", pc); else n_pass++;
    n_total++; if (sp !== 3'd0) $display("FAIL udf_sp: got %0d expected 0", sp); else n_pass++;
    n_total++; if (stack_err !== 1'b1) $display("FAIL udf_err: got %b expected 1", stack_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_call_return();
    test_skip();
    test_halt();
    test_wrap();
    test_overflow();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
